// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame FSM states and the parity helper.
// The matching receiver imports the same package.
package uart_pkg;

   localparam int unsigned PARITY_NONE   = 0;
   localparam int unsigned PARITY_ODD    = 1;
   localparam int unsigned PARITY_EVEN   = 2;
   localparam int unsigned MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   // Unused upper bits are zero, so they do not disturb the reduction.
   function automatic logic parity_bit(logic [MAX_DATA_BITS-1:0] data, int unsigned mode);
      logic p;
      p = 1'b0;
      if (mode == PARITY_ODD) begin
         p = ~^data;
      end else if (mode == PARITY_EVEN) begin
         p = ^data;
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter behind a small input FIFO. Frame: start, data LSB first,
// optional parity, STOP_BITS stop bits; back-to-back frames have no idle gap.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          data_valid,
   output logic                          data_ready,
   output logic                          tx_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned BitPeriod = CLK_FREQ / BAUD_RATE;
   localparam int unsigned BaudW     = (BitPeriod > 1) ? $clog2(BitPeriod) : 1;
   localparam int unsigned BitW      = $clog2(DATA_BITS + 1);

   if (BitPeriod < 2) begin : g_bad_baud
      $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY > PARITY_EVEN) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   uart_state_e          state_q, state_d;
   logic [BaudW-1:0]     baud_q, baud_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 load;
   logic                 baud_tick;
   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_data;

   assign data_ready = !fifo_full;
   assign fifo_push  = data_valid && data_ready;
   assign baud_tick  = (baud_q == BaudW'(BitPeriod - 1));
   assign tx_out     = tx_q;
   assign tx_busy    = (state_q != StIdle);

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  (data_in),
      .pop_i   (fifo_pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      load     = 1'b0;
      fifo_pop = 1'b0;
      tx_d     = 1'b1;

      if (state_q == StIdle) begin
         baud_d = '0;
         load   = !fifo_empty;
      end else if (!baud_tick) begin
         baud_d = baud_q + 1'b1;
      end else begin
         baud_d = '0;
         bit_d  = '0;
         unique case (state_q)
            StStart:  state_d = StData;
            StData: begin
               if (bit_q == BitW'(DATA_BITS - 1)) begin
                  state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end
            StParity: state_d = StStop;
            StStop: begin
               if (bit_q == BitW'(STOP_BITS - 1)) begin
                  load    = !fifo_empty;
                  state_d = StIdle;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
            default:  state_d = StIdle;
         endcase
      end

      // Popping straight into START keeps consecutive frames gap-free.
      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_data;
         par_d    = parity_bit(MAX_DATA_BITS'(fifo_data), PARITY);
         state_d  = StStart;
      end

      unique case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame tables on four configurations, plus a cycle reference
// model and a line decoder scoreboard on the 8N1 instance.
module tb_uart_tx_fifo;

   localparam int unsigned BP     = 10;
   localparam int unsigned Depth  = 4;
   localparam int unsigned FrameA = 10 * BP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid [4];
   logic [7:0] din   [4];
   logic       ready [4];
   logic       tx    [4];
   logic       busy  [4];
   logic [2:0] cnt   [4];

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
      .clk(clk), .rst(rst), .data_in(din[0]), .data_valid(valid[0]), .data_ready(ready[0]),
      .tx_out(tx[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));
   uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .data_in(din[1]), .data_valid(valid[1]), .data_ready(ready[1]),
      .tx_out(tx[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));
   uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
      .clk(clk), .rst(rst), .data_in(din[2]), .data_valid(valid[2]), .data_ready(ready[2]),
      .tx_out(tx[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));
   uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(7),
                  .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
      .clk(clk), .rst(rst), .data_in(din[3][6:0]), .data_valid(valid[3]), .data_ready(ready[3]),
      .tx_out(tx[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %s expected %s", name, act, exp);
      end
   endtask

   function automatic string bstr(input logic b);
      if (b === 1'b1) return "1";
      if (b === 1'b0) return "0";
      return "x";
   endfunction

   // Reference model of instance A: a word queue plus the frame currently on the line.
   int unsigned mq[$];
   bit          m_busy = 1'b0;
   int unsigned m_pos  = 0;
   bit [9:0]    m_frame;
   bit          chk_en = 1'b0;

   function automatic bit [9:0] frame_8n1(input int unsigned w);
      return {1'b1, 8'(w), 1'b0};
   endfunction

   task automatic model_step();
      int unsigned pre;
      bit          take, ended;
      pre   = mq.size();
      take  = (valid[0] === 1'b1) && (pre != Depth);
      ended = 1'b0;
      if (m_busy) begin
         m_pos++;
         ended = (m_pos == FrameA);
      end
      if ((!m_busy || ended) && pre != 0) begin
         m_frame = frame_8n1(mq.pop_front());
         m_busy  = 1'b1;
         m_pos   = 0;
      end else if (ended) begin
         m_busy = 1'b0;
      end
      if (take) mq.push_back(din[0]);
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         mq.delete();
         m_busy = 1'b0;
         m_pos  = 0;
      end else begin
         model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("a_tx_out", tx[0], m_busy ? m_frame[4'(m_pos / BP)] : 1'b1);
         check("a_tx_busy", busy[0], m_busy);
         check("a_fifo_count", cnt[0], mq.size());
         check("a_data_ready", ready[0], mq.size() != Depth);
      end
   end

   // Line decoder for instance A: samples mid-bit and queues the recovered words.
   int unsigned rx_q[$];
   int unsigned sent_q[$];
   bit          mon_en = 1'b0;
   logic [7:0]  rx_w;

   initial forever begin
      @(negedge clk);
      if (mon_en && tx[0] === 1'b0) begin
         repeat (BP / 2) @(negedge clk);
         check("rx_start_mid", tx[0], 1'b0);
         for (int b = 0; b < 8; b++) begin
            repeat (BP) @(negedge clk);
            rx_w[b] = tx[0];
         end
         repeat (BP) @(negedge clk);
         check("rx_stop_mid", tx[0], 1'b1);
         rx_q.push_back(rx_w);
      end
   end

   task automatic drive_a(input bit v, input logic [7:0] d, output bit taken);
      valid[0] = v;
      din[0]   = d;
      @(negedge clk);
      taken = v && (ready[0] === 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int unsigned budget);
      int unsigned w = 0;
      while ((busy[0] !== 1'b0 || cnt[0] !== 3'd0) && w < budget) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("drain_in_budget", w < budget, 1'b1);
      repeat (BP) @(posedge clk);
      #1;
   endtask

   task automatic scoreboard();
      check("sb_count", rx_q.size(), sent_q.size());
      for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
         check("sb_word", rx_q[i], sent_q[i]);
      end
      rx_q.delete();
      sent_q.delete();
   endtask

   typedef struct {
      string       name;
      bit [1:0]    idx;
      int unsigned word;
      string       lv;
   } vec_t;

   function automatic vec_t mk(input string n, input bit [1:0] i, input int unsigned w,
                               input string l);
      vec_t v;
      v.name = n;
      v.idx  = i;
      v.word = w;
      v.lv   = l;
      return v;
   endfunction

   // Push one word into an idle instance and compare every cycle of the frame.
   task automatic run_vec(input vec_t v);
      string       got_tx, got_busy, exp_tx, exp_busy;
      int unsigned f;
      f        = v.lv.len() * BP;
      got_tx   = "";
      got_busy = "";
      exp_tx   = "";
      exp_busy = "";
      din[v.idx]   = 8'(v.word);
      valid[v.idx] = 1'b1;
      @(posedge clk);
      #1;
      valid[v.idx] = 1'b0;
      for (int unsigned s = 0; s <= f + 1; s++) begin
         if (s > 0) begin
            @(posedge clk);
            #1;
         end
         got_tx   = {got_tx, bstr(tx[v.idx])};
         got_busy = {got_busy, bstr(busy[v.idx])};
         if (s == 0 || s == f + 1) begin
            exp_tx   = {exp_tx, "1"};
            exp_busy = {exp_busy, "0"};
         end else begin
            exp_tx   = {exp_tx, v.lv.substr((s - 1) / BP, (s - 1) / BP)};
            exp_busy = {exp_busy, "1"};
         end
      end
      check_str({v.name, "_tx"}, got_tx, exp_tx);
      check_str({v.name, "_busy"}, got_busy, exp_busy);
      check({v.name, "_count"}, cnt[v.idx], 3'd0);
   endtask

   vec_t        vecs[7];
   logic [7:0]  words[8];
   int unsigned acc_cyc[$];
   int unsigned n, cyc;
   bit          taken, v;
   logic [7:0]  d;

   initial begin
      vecs[0] = mk("a5_8n1", 2'd0, 32'hA5, "0101001011");
      vecs[1] = mk("ab_8e1", 2'd1, 32'hAB, "01101010111");
      vecs[2] = mk("cc_8e1", 2'd1, 32'hCC, "00011001101");
      vecs[3] = mk("ab_8o1", 2'd2, 32'hAB, "01101010101");
      vecs[4] = mk("cc_8o1", 2'd2, 32'hCC, "00011001111");
      vecs[5] = mk("55_7n2", 2'd3, 32'h55, "0101010111");
      vecs[6] = mk("3c_after_rst", 2'd0, 32'h3C, "0001111001");
      for (int i = 0; i < 8; i++) words[i] = 8'(8'h11 * (i + 1));
      for (int i = 0; i < 4; i++) begin
         valid[i] = 1'b0;
         din[i]   = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         check("rst_tx_out", tx[i], 1'b1);
         check("rst_tx_busy", busy[i], 1'b0);
         check("rst_fifo_count", cnt[i], 3'd0);
         check("rst_data_ready", ready[i], 1'b1);
      end
      rst    = 1'b0;
      chk_en = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Burst with data_valid held high, including a push that meets a pop while full.
      mon_en = 1'b1;
      n      = 0;
      cyc    = 0;
      while (n < 8 && cyc < 2000) begin
         drive_a(1'b1, words[n], taken);
         cyc++;
         if (taken) begin
            acc_cyc.push_back(cyc);
            sent_q.push_back(words[n]);
            n++;
         end
      end
      valid[0] = 1'b0;
      check("burst_accepted", n, 8);
      if (n == 8) begin
         check("first5_consecutive", acc_cyc[4] - acc_cyc[0], 4);
         check("gap_after_full", acc_cyc[5] - acc_cyc[4], 98);
         check("one_per_frame", acc_cyc[6] - acc_cyc[5], FrameA);
      end
      drain(1000);
      scoreboard();
      mon_en = 1'b0;

      // Reset in data bit 3 of 0xF0 with two more words queued.
      drive_a(1'b1, 8'hF0, taken);
      drive_a(1'b1, 8'h0F, taken);
      drive_a(1'b1, 8'h99, taken);
      valid[0] = 1'b0;
      repeat (44) @(posedge clk);
      #1;
      check("pre_rst_count", cnt[0], 3'd2);
      check("pre_rst_tx", tx[0], 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_tx", tx[0], 1'b1);
      check("async_rst_busy", busy[0], 1'b0);
      check("async_rst_count", cnt[0], 3'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      run_vec(vecs[6]);

      mon_en = 1'b1;
      v      = 1'b0;
      d      = '0;
      taken  = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (!v || taken) begin
            v = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
         end
         drive_a(v, d, taken);
         if (taken) sent_q.push_back(d);
      end
      valid[0] = 1'b0;
      drain(1000);
      scoreboard();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter.
- Real baud-rate timing derived from the system clock frequency.
- Configurable data width, parity mode and stop-bit count.
- Small input FIFO behind a valid/ready handshake, so producers can queue bytes without polling tx_busy.
- Sits between on-chip producers (CPU, test logic) and the board TX pin. A matching receiver follows as a separate block.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits/s; BIT_PERIOD = CLK_FREQ/BAUD_RATE clocks per bit, must be >= 2 (elaboration error otherwise)
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 none, 1 odd, 2 even; other values are an elaboration error
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, input FIFO entries, power of two >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
data_in  in  DATA_BITS  word to transmit, sent LSB first
data_valid  in  1  producer has a word on data_in
data_ready  out  1  FIFO not full; word is accepted on any edge with data_valid && data_ready
tx_out  out  1  serial line, idle high
tx_busy  out  1  high while a frame is on the line
fifo_count  out  $clog2(FIFO_DEPTH)+1  words queued, not yet started

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high on rst.
- Reset values: tx_out=1, tx_busy=0, fifo_count=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
- data_ready = (fifo_count != FIFO_DEPTH), combinational.
- Full FIFO: a push with data_ready low is ignored. On a simultaneous pop while full, data_ready is still low that cycle and the push is not taken.
- Producer must hold data_in stable while data_valid && !data_ready.

FSM states and transitions:
- IDLE: when fifo_count != 0, pop the head into the shift register, clear the baud counter, go to START. tx_out=0 and tx_busy=1 from that edge.
- START, DATA, PARITY, STOP: each bit lasts exactly BIT_PERIOD clocks. The baud counter runs 0..BIT_PERIOD-1; on its terminal count the FSM advances and the counter wraps to 0.
- DATA: shift right, tx_out = shift_reg[0]. After DATA_BITS bits go to PARITY if PARITY != 0, else STOP.
- PARITY: odd sends ~^data; even sends ^data, computed on the popped word.
- STOP: tx_out=1 for STOP_BITS*BIT_PERIOD clocks. At the terminal count:
  - FIFO non-empty: pop and enter START directly. No idle cycle; tx_busy stays high.
  - FIFO empty: enter IDLE, tx_busy=0.

Timing:
- Latency: word accepted at edge E into an empty FIFO with FSM in IDLE -> tx_out falls at edge E+1.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BIT_PERIOD clocks exactly.

Boundary and reset cases:
- Push and pop on the same edge: fifo_count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: line returns high immediately (asynchronous), the FIFO is flushed, and the partial frame is abandoned.
- Counter widths: baud counter $clog2(BIT_PERIOD); bit counter $clog2(DATA_BITS+1).

Decomposition:
- Shared package uart_pkg:
  - parity constants PARITY_NONE/ODD/EVEN
  - FSM state encodings IDLE/START/DATA/PARITY/STOP
  - parity function (data, mode)
  - receiver will reuse all of these
- Sub-module uart_sync_fifo (DATA_BITS wide, FIFO_DEPTH deep, push/pop/full/empty/count, same clk/rst). Shares nothing with the FSM except the handshake.

Test Plan (CLK_FREQ=100_000_000, BAUD_RATE=10_000_000 -> BIT_PERIOD=10):
1. 8N1, push 0xA5 once -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each level exactly 10 clocks. tx_busy high for exactly 100 clocks. fifo_count back to 0.
2. PARITY=2, push 0xAB then 0xCC -> parity bits 1 then 0. PARITY=1, same words -> 0 then 1. Frame 110 clocks each.
3. DATA_BITS=7, STOP_BITS=2, push 0x55 -> 0,1,0,1,0,1,0,1,1,1, 100 clocks total.
4. FIFO_DEPTH=4, data_valid held high with 8 distinct words:
   - first 5 accepted on consecutive edges;
   - data_ready falls after the 5th and rises for one word per frame;
   - 8 frames emitted in order with no idle gap between stop and start bits;
   - tx_busy never drops until the last stop bit ends.
5. Assert rst during data bit 3 of 0xF0 with 2 words queued -> tx_out=1, tx_busy=0, fifo_count=0 immediately. After release, push 0x3C -> clean, correct frame.
6. Simultaneous push/pop at full (FIFO full, stop bit ends while data_valid high) -> push not accepted that edge, accepted next edge, no word lost or duplicated (scoreboard compare).
